eager_join_capture_block: RTL and testbench
===========================================

# eager_join_capture_block

Synchronizing join for dataflow circuits: merges NUM_INPUTS valid/ready channels into one output channel carrying the concatenated data. Each input is acknowledged eagerly, as soon as its token arrives, and the token is parked in a per-input capture slot until every other input has also delivered. This is the merge-side counterpart of the eager fork. It sits wherever a dataflow unit needs all operands present and upstream producers must not stall on each other.

## Interface
- NUM_INPUTS, default 2: number of input channels, at least 2.
- DATA_WIDTH, default 32: width of each input's data, at least 1.

- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-low.
- ins_valid  input  NUM_INPUTS  per-input valid.
- ins_data  input  NUM_INPUTS*DATA_WIDTH  input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ins_ready  output  NUM_INPUTS  per-input ready.
- outs_valid  output  1  joined token valid.
- outs_data  output  NUM_INPUTS*DATA_WIDTH  joined data, same packing as ins_data.
- outs_ready  input  1  downstream ready.
- slots_full  output  NUM_INPUTS  per-input capture-slot occupancy, for debug and verification.

## Operation
- Per input i, the block holds one state bit held[i] and one DATA_WIDTH data register slot[i].
- Effective valid: ev[i] = held[i] | ins_valid[i].
- Effective data: ed[i] = held[i] ? slot[i] : ins_data[i].
- outs_valid = AND over i of ev[i].
- outs_data = concatenation of ed[i].
- fire = outs_valid & outs_ready.
- ins_ready[i] = ~held[i]. This is combinational from state only and never depends on outs_ready, so there is no ready-to-ready combinational path.
- Input transfer on i occurs when ins_valid[i] & ins_ready[i].
- Next state per i:
  - fire: held[i] <= 0. A live (non-held) input is consumed directly into the output in the same cycle.
  - Not fire and input transfer on i: held[i] <= 1, slot[i] <= ins_data[i].
  - Otherwise: hold.
- slot[i] updates only on capture; its contents while held[i]=0 are don't-care.
- slots_full = held.
- Invariants:
  - A token is never duplicated or dropped.
  - Each output token contains exactly one token from each input, in arrival order per input.
- Only outs_valid and outs_data have combinational paths from inputs (ins_valid/ins_data to outs). ins_ready is registered-state only.

## Timing
- Reset (rst=0, asynchronous): held=0 and slot=0 immediately, without waiting for a clock edge. After reset:
  - ins_ready = all ones.
  - slots_full = 0.
  - outs_valid = AND(ins_valid).
  - outs_data = ins_data.
- Latency: 0 cycles when all inputs are valid in the same cycle and outs_ready=1. The output fires combinationally and no slot is written.
- Early input: captured at the edge where it transfers. Its ins_ready drops the next cycle and stays low until the edge of the cycle in which fire occurs.
- Throughput: 1 joined token per cycle when all inputs are continuously valid and outs_ready=1.
  - After a capture on input i, i accepts its next token no earlier than the cycle after fire.
- Simultaneous fire and ins_valid on a held input: the held token is consumed, ins_ready[i]=0 that cycle, and the new token is not accepted. It is taken the next cycle.
- Backpressure: with outs_ready=0, every input is captured at most once, after which ins_ready drops. outs_valid remains asserted and outs_data stays stable.
- Output stability: once all slots are held, outs_data is stable until fire.
- Reset mid-operation: held tokens are discarded and the block returns to the post-reset state asynchronously. The first clock edge after rst deasserts is a normal cycle.

## Test plan
- Aligned arrival, NUM_INPUTS=3, DATA_WIDTH=8: ins_valid=3'b111, data {0x33,0x22,0x11}, outs_ready=1 -> same cycle outs_valid=1, outs_data=0x332211, ins_ready=3'b111, slots_full stays 0.
- Staggered arrival: input0 valid with 0xA0 at cycle 0, input1 with 0xB1 at cycle 2, input2 with 0xC2 at cycle 4 (each input deasserts valid after its handshake), outs_ready=1 -> slots_full=3'b001 after cycle 0 and 3'b011 after cycle 2; outs_valid=1 only in cycle 4 with outs_data=0xC2B1A0; slots_full=0 after cycle 4.
- Backpressure: all inputs valid, outs_ready=0 for 5 cycles -> captured at first edge, ins_ready=0 and outs_data constant for cycles 1-5; raise outs_ready -> exactly one fire, then ins_ready=3'b111.
- Repeat token on held input: input0 sends 0x01 then immediately 0x02 while input1 is idle -> 0x02 stalls with ins_ready[0]=0; input1 sends 0x10 twice -> outputs 0x1001 then 0x1002, in order, with no loss.
- Async reset mid-capture: slots_full=3'b011, pull rst low between clock edges -> slots_full=0 and ins_ready=all ones before the next edge; the previously held data never appears on the output.
- Streaming: all inputs valid every cycle with incrementing data for 20 cycles, outs_ready=1 -> 20 fires in 20 consecutive cycles with matching data.

Source files
------------

// File: rtl/eager_join_capture_block.sv
// ============================================================================
// Module   : eager_join_capture_block
// Brief    : Synchronizing join that acknowledges every input eagerly and parks
//            early tokens in per-input capture slots until all inputs arrive.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eager_join_capture_block #(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            ins_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins_data,
  output logic [NUM_INPUTS-1:0]            ins_ready,
  output logic                             outs_valid,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] outs_data,
  input  logic                             outs_ready,
  output logic [NUM_INPUTS-1:0]            slots_full
);

  logic [NUM_INPUTS-1:0]            held;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] slot;
  logic [NUM_INPUTS-1:0]            eff_valid;
  logic                             fire;

  assign eff_valid  = held | ins_valid;
  assign outs_valid = &eff_valid;
  assign fire       = outs_valid & outs_ready;

  // Ready comes from state alone, so downstream ready never reaches upstream.
  assign ins_ready  = ~held;
  assign slots_full = held;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held <= '0;
    end else if (fire) begin
      held <= '0;
    end else begin
      held <= held | (ins_valid & ~held);
    end
  end

  generate
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
      assign outs_data[i*DATA_WIDTH +: DATA_WIDTH] =
        held[i] ? slot[i*DATA_WIDTH +: DATA_WIDTH] : ins_data[i*DATA_WIDTH +: DATA_WIDTH];

      // A live input consumed by a firing join goes straight through, never into the slot.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
        end else if (!fire && ins_valid[i] && !held[i]) begin
          slot[i*DATA_WIDTH +: DATA_WIDTH] <= ins_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_eager_join_capture_block.sv
// ============================================================================
// Module   : tb_eager_join_capture_block
// Brief    : Scoreboard bench for eager_join_capture_block (3 inputs x 8 bits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eager_join_capture_block;

  localparam int NUM_INPUTS = 3;
  localparam int DATA_WIDTH = 8;

  logic                             clk = 1'b0;
  logic                             rst = 1'b0;
  logic [NUM_INPUTS-1:0]            ins_valid = '0;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins_data = '0;
  logic [NUM_INPUTS-1:0]            ins_ready;
  logic                             outs_valid;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] outs_data;
  logic                             outs_ready = 1'b0;
  logic [NUM_INPUTS-1:0]            slots_full;

  int n_checks = 0;
  int n_fail   = 0;
  int fires    = 0;
  logic [23:0] sb[$];

  eager_join_capture_block #(
    .NUM_INPUTS(NUM_INPUTS),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ins_valid (ins_valid),
    .ins_data  (ins_data),
    .ins_ready (ins_ready),
    .outs_valid(outs_valid),
    .outs_data (outs_data),
    .outs_ready(outs_ready),
    .slots_full(slots_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Every joined token leaving the block must match the oldest expected one.
  always @(negedge clk) begin
    if (rst && outs_valid && outs_ready) begin
      fires++;
      if (sb.size() == 0) check("unexpected_fire", {8'h0, outs_data}, 32'h0);
      else check("sb_data", {8'h0, outs_data}, {8'h0, sb.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0;
    // Reset state, observed before any clock edge
    #3;
    check("rst_ready", ins_ready, 3'b111);
    check("rst_full", slots_full, 3'b000);
    check("rst_ovalid", outs_valid, 1'b0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // Aligned arrival
    outs_ready = 1'b1;
    ins_valid = 3'b111; ins_data = 24'h332211; sb.push_back(24'h332211);
    #1;
    check("align_valid", outs_valid, 1'b1);
    check("align_data", outs_data, 24'h332211);
    check("align_ready", ins_ready, 3'b111);
    next_cycle();
    ins_valid = '0;
    check("align_full", slots_full, 3'b000);

    // Staggered arrival
    ins_valid = 3'b001; ins_data = 24'h0000A0; sb.push_back(24'hC2B1A0);
    #1 check("stag_c0_valid", outs_valid, 1'b0);
    next_cycle();
    ins_valid = '0;
    check("stag_full0", slots_full, 3'b001);
    next_cycle();
    ins_valid = 3'b010; ins_data = 24'h00B100;
    #1 check("stag_c2_valid", outs_valid, 1'b0);
    next_cycle();
    ins_valid = '0;
    check("stag_full1", slots_full, 3'b011);
    next_cycle();
    ins_valid = 3'b100; ins_data = 24'hC20000;
    #1 check("stag_c4_valid", outs_valid, 1'b1);
    check("stag_c4_data", outs_data, 24'hC2B1A0);
    next_cycle();
    ins_valid = '0;
    check("stag_full2", slots_full, 3'b000);

    // Backpressure
    outs_ready = 1'b0;
    ins_valid = 3'b111; ins_data = 24'h665544; sb.push_back(24'h665544);
    next_cycle();
    ins_valid = '0;
    for (int c = 0; c < 5; c++) begin
      ins_data = 24'(c * 24'h010203 + 24'h0A0B0C);
      #1;
      check("bp_ready", ins_ready, 3'b000);
      check("bp_valid", outs_valid, 1'b1);
      check("bp_data", outs_data, 24'h665544);
      next_cycle();
    end
    f0 = fires;
    outs_ready = 1'b1;
    next_cycle();
    check("bp_one_fire", fires - f0, 1);
    check("bp_ready_after", ins_ready, 3'b111);
    next_cycle();
    check("bp_no_extra", fires - f0, 1);

    // Repeat token on a held input
    ins_valid = 3'b001; ins_data = 24'h000001;
    sb.push_back(24'h201001); sb.push_back(24'h211002);
    next_cycle();
    ins_data = 24'h000002;
    #1 check("rep_stall", ins_ready, 3'b110);
    next_cycle();
    ins_valid = 3'b111; ins_data = 24'h201002;
    #1 check("rep_fire_ready", ins_ready, 3'b110);
    next_cycle();
    ins_data = 24'h211002;
    #1 check("rep_second_ready", ins_ready, 3'b111);
    next_cycle();
    ins_valid = '0;
    check("rep_full", slots_full, 3'b000);

    // Asynchronous reset while two slots are held
    outs_ready = 1'b0;
    ins_valid = 3'b011; ins_data = 24'h00EEDD;
    next_cycle();
    ins_valid = '0;
    check("ar_full_pre", slots_full, 3'b011);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("ar_full", slots_full, 3'b000);
    check("ar_ready", ins_ready, 3'b111);
    #1 rst = 1'b1;
    next_cycle();
    outs_ready = 1'b1;
    ins_valid = 3'b111; ins_data = 24'h554433; sb.push_back(24'h554433);
    next_cycle();
    ins_valid = '0;

    // Streaming
    f0 = fires;
    for (int i = 0; i < 20; i++) begin
      logic [23:0] w;
      w = {8'(3 * i + 2), 8'(3 * i + 1), 8'(3 * i)};
      ins_valid = 3'b111; ins_data = w; sb.push_back(w);
      #1 check("stream_ready", ins_ready, 3'b111);
      next_cycle();
    end
    ins_valid = '0;
    next_cycle();
    check("stream_fires", fires - f0, 20);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
